// File: rtl/prores_seq_pkg.sv
// prores_seq_pkg: shared FSM state type and default pipeline timing for the slice sequencer.
// Revision 1.0
`default_nettype none

package prores_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DCT_TIME_DEFAULT  = 12;
    localparam int VLC_DRAIN_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/seq_window_decode.sv
// seq_window_decode: decodes feed / VLC windows and the last RUN cycle from the slice counter.
// Revision 1.0
`default_nettype none

module seq_window_decode
    import prores_seq_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int BLK_W     = 16,
    parameter int DCT_TIME  = DCT_TIME_DEFAULT,
    parameter int VLC_DRAIN = VLC_DRAIN_DEFAULT
) (
    input  logic             running,
    input  logic [CNT_W-1:0] count,
    input  logic [BLK_W-1:0] blocks,
    output logic             feed,
    output logic             vlc_init,
    output logic             vlc_window,
    output logic             last_cycle
);

    logic [CNT_W-1:0] n_ext;
    logic [CNT_W-1:0] dct_start;
    logic [CNT_W-1:0] vlc_end;
    logic [CNT_W-1:0] last_idx;

    // blocks is never zero while running, so none of these subtractions underflow.
    assign n_ext     = CNT_W'(blocks);
    assign dct_start = CNT_W'(DCT_TIME);
    assign vlc_end   = dct_start + n_ext - CNT_W'(1);
    assign last_idx  = vlc_end + CNT_W'(VLC_DRAIN);

    assign feed       = running && (count < n_ext);
    assign vlc_init   = running && (count == dct_start - CNT_W'(1));
    assign vlc_window = running && (count >= dct_start) && (count <= vlc_end);
    assign last_cycle = running && (count == last_idx - CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/slice_sequencer.sv
// slice_sequencer: per-slice DCT feed / VLC timing FSM; optional slice_count via SLICE_SEQUENCER_SLICE_COUNT_EN.
// Revision 1.0
`default_nettype none

module slice_sequencer
    import prores_seq_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int BLK_W     = 16,
    parameter int DCT_TIME  = DCT_TIME_DEFAULT,
    parameter int VLC_DRAIN = VLC_DRAIN_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             slice_start,
    input  logic [BLK_W-1:0] block_num,
    output logic             slice_ready,
    output logic [CNT_W-1:0] sequence_counter,
    output logic             sequence_valid,
    output logic             feed_valid,
    output logic             vlc_reset,
    output logic             vlc_valid,
    output logic             slice_done
`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
    ,
    output logic [31:0]      slice_count
`endif
);

    generate
        if (BLK_W >= CNT_W) begin : g_width_check
            $error("slice_sequencer: BLK_W must be smaller than CNT_W");
        end
    endgenerate

    seq_state_t       state;
    logic [BLK_W-1:0] blocks;
    logic             last_cycle;

    seq_window_decode #(
        .CNT_W     (CNT_W),
        .BLK_W     (BLK_W),
        .DCT_TIME  (DCT_TIME),
        .VLC_DRAIN (VLC_DRAIN)
    ) u_window (
        .running    (state == RUN),
        .count      (sequence_counter),
        .blocks     (blocks),
        .feed       (feed_valid),
        .vlc_init   (vlc_reset),
        .vlc_window (vlc_valid),
        .last_cycle (last_cycle)
    );

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state            <= IDLE;
            blocks           <= '0;
            sequence_counter <= '0;
            sequence_valid   <= 1'b0;
            slice_ready      <= 1'b1;
            slice_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slice_start && (block_num != '0)) begin
                        state            <= RUN;
                        blocks           <= block_num;
                        sequence_counter <= '0;
                        sequence_valid   <= 1'b1;
                        slice_ready      <= 1'b0;
                    end
                end
                RUN: begin
                    sequence_counter <= sequence_counter + CNT_W'(1);
                    if (last_cycle) begin
                        state      <= DONE;
                        slice_done <= 1'b1;
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    sequence_counter <= '0;
                    sequence_valid   <= 1'b0;
                    slice_done       <= 1'b0;
                    slice_ready      <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            slice_count <= '0;
        end else if (state == DONE) begin
            slice_count <= slice_count + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_slice_sequencer.sv
// tb_slice_sequencer: directed stimulus with a slice-timeline reference model and per-cycle compare.
// Revision 1.0
`default_nettype none

module tb_slice_sequencer;

    localparam int CNT_W = 32;
    localparam int BLK_W = 16;
    localparam int DCT   = 12;
    localparam int DRAIN = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             slice_start = 1'b0;
    logic [BLK_W-1:0] block_num = '0;
    logic             slice_ready;
    logic [CNT_W-1:0] sequence_counter;
    logic             sequence_valid;
    logic             feed_valid;
    logic             vlc_reset;
    logic             vlc_valid;
    logic             slice_done;
`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
    logic [31:0]      slice_count;
`endif

    always #5 clock = ~clock;

    slice_sequencer #(
        .CNT_W     (CNT_W),
        .BLK_W     (BLK_W),
        .DCT_TIME  (DCT),
        .VLC_DRAIN (DRAIN)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .slice_start      (slice_start),
        .block_num        (block_num),
        .slice_ready      (slice_ready),
        .sequence_counter (sequence_counter),
        .sequence_valid   (sequence_valid),
        .feed_valid       (feed_valid),
        .vlc_reset        (vlc_reset),
        .vlc_valid        (vlc_valid),
        .slice_done       (slice_done)
`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
        ,
        .slice_count      (slice_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a slice is a start time plus a length; every output is a
    // function of the cycle offset into the slice.
    bit m_active = 1'b0;
    int m_idx = 0;
    int m_n = 0;
    int m_slices = 0;

    always @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_n      = 0;
            m_slices = 0;
        end else if (m_active) begin
            if (m_idx == DCT + m_n - 1 + DRAIN) begin
                m_active = 1'b0;
                m_idx    = 0;
                m_slices = m_slices + 1;
            end else begin
                m_idx = m_idx + 1;
            end
        end else if (slice_start && block_num != 0) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_n      = int'(block_num);
        end
    end

    int rec_feed_first, rec_feed_last, rec_feed_cnt;
    int rec_vr, rec_vr_cnt;
    int rec_vv_first, rec_vv_last, rec_vv_cnt;
    int rec_done;

    task automatic clr_rec();
        rec_feed_first = -1; rec_feed_last = -1; rec_feed_cnt = 0;
        rec_vr = -1; rec_vr_cnt = 0;
        rec_vv_first = -1; rec_vv_last = -1; rec_vv_cnt = 0;
        rec_done = -1;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            check("ready", slice_ready, !m_active);
            check("seq_valid", sequence_valid, m_active);
            check("counter", sequence_counter, m_active ? m_idx : 0);
            check("feed", feed_valid, m_active && m_idx < m_n);
            check("vlc_reset", vlc_reset, m_active && m_idx == DCT - 1);
            check("vlc_valid", vlc_valid, m_active && m_idx >= DCT && m_idx <= DCT + m_n - 1);
            check("done", slice_done, m_active && m_idx == DCT + m_n - 1 + DRAIN);
`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
            check("slice_count", slice_count, m_slices);
`endif
        end
        if (feed_valid) begin
            if (rec_feed_first < 0) rec_feed_first = int'(sequence_counter);
            rec_feed_last = int'(sequence_counter);
            rec_feed_cnt++;
        end
        if (vlc_reset) begin
            rec_vr = int'(sequence_counter);
            rec_vr_cnt++;
        end
        if (vlc_valid) begin
            if (rec_vv_first < 0) rec_vv_first = int'(sequence_counter);
            rec_vv_last = int'(sequence_counter);
            rec_vv_cnt++;
        end
        if (slice_done) rec_done = int'(sequence_counter);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, slice_ready, 1);
        check({tag, "_valid"}, sequence_valid, 0);
        check({tag, "_counter"}, sequence_counter, 0);
        check({tag, "_feed"}, feed_valid, 0);
        check({tag, "_vlc_reset"}, vlc_reset, 0);
        check({tag, "_vlc_valid"}, vlc_valid, 0);
        check({tag, "_done"}, slice_done, 0);
    endtask

    // Runs one slice from the current (ready) cycle; optionally pokes slice_start at counter 5.
    task automatic run_slice(input int n, input bit pulse, input int exp_feed_last,
                             input int exp_vv_first, input int exp_vv_last, input int exp_done);
        bit seen;
        clr_rec();
        slice_start = 1'b1;
        block_num   = BLK_W'(n);
        step();
        slice_start = 1'b0;
        block_num   = '0;
        check("accept_valid", sequence_valid, 1);
        check("accept_counter", sequence_counter, 0);
        seen = slice_done;
        for (int k = 0; k < 300 && !seen; k++) begin
            slice_start = pulse && (sequence_counter == 5);
            block_num   = slice_start ? BLK_W'(3) : '0;
            step();
            seen = slice_done;
        end
        slice_start = 1'b0;
        block_num   = '0;
        check("done_seen", seen, 1);
        step();
        check("ready_after_done", slice_ready, 1);
        check("feed_first", rec_feed_first, 0);
        check("feed_last", rec_feed_last, exp_feed_last);
        check("vlc_reset_at", rec_vr, 11);
        check("vlc_reset_once", rec_vr_cnt, 1);
        check("vlc_first", rec_vv_first, exp_vv_first);
        check("vlc_last", rec_vv_last, exp_vv_last);
        check("done_at", rec_done, exp_done);
    endtask

    initial begin
        bit hit;
        clr_rec();
        repeat (2) @(negedge clock);
        #1;
        check_reset_values("rst");
        reset_n = 1'b0;
        step();
        check_reset_values("idle");

        run_slice(8, 1'b0, 7, 12, 19, 23);
        run_slice(1, 1'b0, 0, 12, 12, 16);
        run_slice(8, 1'b1, 7, 12, 19, 23);

        slice_start = 1'b1;
        block_num   = '0;
        step();
        slice_start = 1'b0;
        step();
        check_reset_values("zero_blocks");

        clr_rec();
        slice_start = 1'b1;
        block_num   = BLK_W'(8);
        step();
        slice_start = 1'b0;
        block_num   = '0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (sequence_counter == 14) hit = 1'b1;
            else step();
        end
        check("reach_14", hit, 1);
        check("vlc_valid_at_14", vlc_valid, 1);
        reset_n = 1'b1;
        #1;
        check_reset_values("mid_rst");
        step();
        step();
        check("no_done_after_rst", rec_done, -1);
        reset_n = 1'b0;
        step();
        run_slice(1, 1'b0, 0, 12, 12, 16);

        reset_n = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        for (int s = 0; s < 3; s++) run_slice(2, 1'b0, 1, 12, 13, 17);
`ifdef SLICE_SEQUENCER_SLICE_COUNT_EN
        check("slice_count_3", slice_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slice_sequencer.md
SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CNT_W  32  sequence_counter width
  BLK_W  16  block_num width; elaboration SHALL fail unless BLK_W < CNT_W
  DCT_TIME  12  cycles from first block fed to first DCT output
  VLC_DRAIN  4  cycles after last VLC input before slice completes
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  clock
  reset_n  in  1  reset, asynchronous, active-high
  slice_start  in  1  request to start a slice
  block_num  in  BLK_W  blocks in the slice, sampled with slice_start
  slice_ready  out  1  idle, start accepted
  sequence_counter  out  CNT_W  cycle index within the slice
  sequence_valid  out  1  slice in progress
  feed_valid  out  1  feed one block to DCT this cycle
  vlc_reset  out  1  one-cycle VLC initialisation pulse
  vlc_valid  out  1  DCT output block valid, feed VLC
  slice_done  out  1  one-cycle completion pulse

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE; there SHALL be one slice in flight at most.
REQ-004 IDLE to RUN SHALL occur on an edge with slice_start=1 and block_num!=0; block_num latched as N; sequence_counter<=0; sequence_valid<=1.
REQ-005 slice_start with block_num=0 SHALL be ignored, with no state or output change.
REQ-006 slice_start outside IDLE SHALL be ignored; slice_ready SHALL be 1 only in IDLE.
REQ-007 In RUN, sequence_counter SHALL increment by 1 every cycle.
REQ-008 feed_valid SHALL be 1 in RUN iff sequence_counter < N.
REQ-009 vlc_reset SHALL be 1 in RUN iff sequence_counter == DCT_TIME-1; this gives exactly one cycle per slice.
REQ-010 vlc_valid SHALL be 1 in RUN iff DCT_TIME <= sequence_counter <= DCT_TIME+N-1.
REQ-011 Let L = DCT_TIME+N-1+VLC_DRAIN; on the edge where sequence_counter becomes L, the state SHALL go to DONE; slice_done SHALL be 1 only in DONE.
REQ-012 DONE to IDLE SHALL occur unconditionally on the next edge; sequence_valid<=0 and sequence_counter<=0.
REQ-013 All outputs SHALL decode from registered state only, with no combinational input-to-output path.
REQ-014 Counter comparisons SHALL be CNT_W-bit unsigned; given REQ-001, sequence_counter SHALL never wrap.

Reset
REQ-015 reset_n=1 SHALL asynchronously force: state IDLE, sequence_counter 0, N 0, sequence_valid 0, feed_valid 0, vlc_reset 0, vlc_valid 0, slice_done 0, slice_ready 1.
REQ-016 Reset mid-slice SHALL abandon the slice without emitting slice_done.

Configuration
REQ-017 With SLICE_SEQUENCER_SLICE_COUNT_EN defined, the block SHALL add output slice_count, 32 bits, reset to 0, incremented in the DONE cycle and wrapping at 2^32.
REQ-018 Without SLICE_SEQUENCER_SLICE_COUNT_EN, the port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 Package prores_seq_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default DCT_TIME and VLC_DRAIN constants.
REQ-020 Window decode (feed, vlc_reset, vlc_valid, last-cycle compare) SHALL live in sub-module seq_window_decode; FSM and counter SHALL stay in slice_sequencer.

Verification (DCT_TIME=12, VLC_DRAIN=4)
REQ-021 Start with block_num=8 -> feed_valid at counter 0..7; vlc_reset at counter 11 only; vlc_valid at 12..19; slice_done at counter 23; slice_ready 1 on the following cycle.
REQ-022 block_num=1 -> feed_valid at counter 0; vlc_valid at 12; slice_done at 16.
REQ-023 slice_start pulsed at counter 5 of a running slice -> ignored; timing identical to REQ-021.
REQ-024 slice_start with block_num=0 in IDLE -> stays IDLE; all outputs unchanged.
REQ-025 reset_n asserted at counter 14 -> all outputs at reset values immediately; no slice_done; a new start then runs normally.
REQ-026 Three back-to-back slices with SLICE_SEQUENCER_SLICE_COUNT_EN defined -> slice_count reads 3; each start is accepted on the first cycle slice_ready=1.
